mcbsp_slaver_tdm: RTL and testbench

Parametrised McBSP slave receiver for the DSP interface. It deserialises one or more words per frame from the DSP McBSP transmit port, clocked by the DSP CLKX. Per frame it supports a programmable word length, word count (TDM channels) and bit order. Completed words are tagged with their channel index and buffered in a first-word-fall-through FIFO with a valid/ready handshake. Frame-sync and overflow errors are flagged.

---
 rtl/mcbsp_slaver_tdm.sv | 202 ++++++++++++++++++++
 tb/tb_mcbsp_slaver_tdm.sv | 467 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mcbsp_slaver_tdm.sv
// McBSP slave receiver: deserialises TDM words clocked by CLKX and queues them,
// tagged with their channel index, in a first-word-fall-through FIFO.
module mcbsp_slaver_tdm #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned CH_W    = 4,
    parameter int unsigned FIFO_AW = 4
) (
    input  logic              mcbsp_slaver_clkx,
    input  logic              mcbsp_slaver_rst,
    input  logic [5:0]        mcbsp_reg_length,
    input  logic [CH_W-1:0]   mcbsp_reg_number,
    input  logic              mcbsp_msb_first,
    input  logic              mcbsp_slaver_fsx,
    input  logic              mcbsp_slaver_mosi,
    output logic [DATA_W-1:0] mcbsp_data_out,
    output logic [CH_W-1:0]   mcbsp_chan_out,
    output logic              mcbsp_vaild_out,
    input  logic              mcbsp_ready_in,
    output logic              mcbsp_frame_err,
    output logic              mcbsp_ovf_err,
    output logic [FIFO_AW:0]  mcbsp_fifo_level,
    output logic [63:0]       debug_signal
);

    localparam int unsigned Depth = 1 << FIFO_AW;
    localparam int unsigned LvlW  = FIFO_AW + 1;

    typedef enum logic {StIdle, StShift} state_e;

    state_e            state_q, state_d;
    logic [5:0]        len_q, len_d;
    logic [5:0]        bit_cnt_q, bit_cnt_d;
    logic [CH_W-1:0]   num_q, num_d;
    logic [CH_W-1:0]   ch_cnt_q, ch_cnt_d;
    logic              msb_q, msb_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              frame_err_q, frame_err_d;
    logic              ovf_q, ovf_d;

    logic [5:0]        len_in;
    logic              in_shift, word_end, last_word, frame_start;
    logic              cur_msb;
    logic [5:0]        cur_idx;
    logic [DATA_W-1:0] base, shifted;
    logic [DATA_W:0]   msb_ext;
    logic              push;
    logic [CH_W-1:0]   push_ch;

    always_comb begin
        len_in = mcbsp_reg_length;
        if (mcbsp_reg_length == 6'd0 || mcbsp_reg_length > 6'(DATA_W)) begin
            len_in = 6'(DATA_W);
        end
    end

    always_comb begin
        in_shift    = (state_q == StShift);
        last_word   = (ch_cnt_q == num_q);
        word_end    = in_shift && (bit_cnt_q == len_q - 6'd1);
        // fsx on the edge finishing the final word is a legal back-to-back frame
        frame_start = mcbsp_slaver_fsx && !(word_end && last_word);

        state_d     = state_q;
        len_d       = len_q;
        num_d       = num_q;
        msb_d       = msb_q;
        bit_cnt_d   = bit_cnt_q;
        ch_cnt_d    = ch_cnt_q;
        shift_d     = shift_q;
        frame_err_d = 1'b0;
        push        = 1'b0;
        push_ch     = ch_cnt_q;

        cur_msb = msb_q;
        cur_idx = bit_cnt_q;
        base    = (bit_cnt_q == 6'd0) ? '0 : shift_q;
        if (frame_start) begin
            cur_msb = mcbsp_msb_first;
            cur_idx = 6'd0;
            base    = '0;
        end
        msb_ext = {base, mcbsp_slaver_mosi};
        shifted = cur_msb ? msb_ext[DATA_W-1:0]
                          : (base | (DATA_W'(mcbsp_slaver_mosi) << cur_idx));

        if (frame_start) begin
            frame_err_d = in_shift;
            len_d       = len_in;
            num_d       = mcbsp_reg_number;
            msb_d       = mcbsp_msb_first;
            shift_d     = shifted;
            ch_cnt_d    = '0;
            state_d     = StShift;
            bit_cnt_d   = 6'd1;
            if (len_in == 6'd1) begin
                push      = 1'b1;
                push_ch   = '0;
                bit_cnt_d = 6'd0;
                if (mcbsp_reg_number == '0) begin
                    state_d = StIdle;
                end else begin
                    ch_cnt_d = CH_W'(1);
                end
            end
        end else if (in_shift) begin
            shift_d = shifted;
            if (word_end) begin
                push      = 1'b1;
                bit_cnt_d = 6'd0;
                if (!last_word) begin
                    ch_cnt_d = ch_cnt_q + CH_W'(1);
                end else if (mcbsp_slaver_fsx) begin
                    // New frame's first bit arrives on the next edge
                    len_d    = len_in;
                    num_d    = mcbsp_reg_number;
                    msb_d    = mcbsp_msb_first;
                    ch_cnt_d = '0;
                end else begin
                    state_d  = StIdle;
                    ch_cnt_d = '0;
                end
            end else begin
                bit_cnt_d = bit_cnt_q + 6'd1;
            end
        end
    end

    logic [CH_W+DATA_W-1:0] mem_q [Depth];
    logic [FIFO_AW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [FIFO_AW:0]       count_q, count_d;
    logic                   full, valid, pop, wr_en;

    always_comb begin
        full    = (count_q == LvlW'(Depth));
        valid   = (count_q != '0);
        pop     = valid && mcbsp_ready_in;
        wr_en   = push && (!full || pop);
        ovf_d   = push && full && !pop;
        count_d = count_q;
        unique case ({wr_en, pop})
            2'b10:   count_d = count_q + LvlW'(1);
            2'b01:   count_d = count_q - LvlW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge mcbsp_slaver_clkx) begin
        if (mcbsp_slaver_rst) begin
            state_q     <= StIdle;
            len_q       <= 6'(DATA_W);
            num_q       <= '0;
            msb_q       <= 1'b0;
            bit_cnt_q   <= 6'd0;
            ch_cnt_q    <= '0;
            shift_q     <= '0;
            frame_err_q <= 1'b0;
            ovf_q       <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            num_q       <= num_d;
            msb_q       <= msb_d;
            bit_cnt_q   <= bit_cnt_d;
            ch_cnt_q    <= ch_cnt_d;
            shift_q     <= shift_d;
            frame_err_q <= frame_err_d;
            ovf_q       <= ovf_d;
            count_q     <= count_d;
            if (wr_en) wr_ptr_q <= wr_ptr_q + FIFO_AW'(1);
            if (pop)   rd_ptr_q <= rd_ptr_q + FIFO_AW'(1);
        end
    end

    always_ff @(posedge mcbsp_slaver_clkx) begin
        if (wr_en) mem_q[wr_ptr_q] <= {push_ch, shifted};
    end

    logic [CH_W+DATA_W-1:0] head;
    logic [3:0]             dbg_ch;
    logic [31:0]            dbg_shift;
    logic [4:0]             dbg_level;

    always_comb begin
        // Gate with valid so stale storage never shows after reset
        head             = valid ? mem_q[rd_ptr_q] : '0;
        mcbsp_data_out   = head[DATA_W-1:0];
        mcbsp_chan_out   = head[CH_W+DATA_W-1:DATA_W];
        mcbsp_vaild_out  = valid;
        mcbsp_frame_err  = frame_err_q;
        mcbsp_ovf_err    = ovf_q;
        mcbsp_fifo_level = count_q;
        dbg_ch           = 4'(ch_cnt_q);
        dbg_shift        = 32'(shift_q);
        dbg_level        = 5'(count_q);
        debug_signal     = {12'd0, dbg_level, ovf_q, frame_err_q, dbg_shift, dbg_ch, bit_cnt_q,
                            (state_q == StShift), mcbsp_slaver_mosi, mcbsp_slaver_fsx};
    end

endmodule

// File: tb/tb_mcbsp_slaver_tdm.sv
// Bench for mcbsp_slaver_tdm: scenario tasks drive serial frames and compare the
// popped FIFO stream against words predicted from the frame configuration.
module tb_mcbsp_slaver_tdm;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [5:0]  reg_length = 6'd0;
    logic [3:0]  reg_number = 4'd0;
    logic        msb_first = 1'b1;
    logic        fsx = 1'b0;
    logic        mosi = 1'b0;
    logic [31:0] data;
    logic [3:0]  chan;
    logic        valid;
    logic        ready = 1'b0;
    logic        frame_err;
    logic        ovf_err;
    logic [2:0]  level;
    logic [63:0] debug;

    int errors = 0;
    int checks = 0;
    int fe_cnt = 0;
    int ovf_cnt = 0;

    logic [35:0] got_q[$];
    logic [35:0] exp_q[$];
    logic [31:0] fw[16];

    mcbsp_slaver_tdm #(.DATA_W(32), .CH_W(4), .FIFO_AW(2)) dut (
        .mcbsp_slaver_clkx (clk),
        .mcbsp_slaver_rst  (rst),
        .mcbsp_reg_length  (reg_length),
        .mcbsp_reg_number  (reg_number),
        .mcbsp_msb_first   (msb_first),
        .mcbsp_slaver_fsx  (fsx),
        .mcbsp_slaver_mosi (mosi),
        .mcbsp_data_out    (data),
        .mcbsp_chan_out    (chan),
        .mcbsp_vaild_out   (valid),
        .mcbsp_ready_in    (ready),
        .mcbsp_frame_err   (frame_err),
        .mcbsp_ovf_err     (ovf_err),
        .mcbsp_fifo_level  (level),
        .debug_signal      (debug)
    );

    always #5 clk = ~clk;

    // Record what the consumer takes and count error pulses
    always @(negedge clk) begin
        if (frame_err) fe_cnt++;
        if (ovf_err) ovf_cnt++;
        if (!rst && valid && ready) got_q.push_back({chan, data});
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_bit(input bit f, input bit m);
        fsx  = f;
        mosi = m;
        tick();
    endtask

    function automatic int eff_len(input logic [5:0] cfg);
        return (cfg == 6'd0 || cfg > 6'd32) ? 32 : int'(cfg);
    endfunction

    function automatic logic [31:0] word_mask(input int l);
        logic [63:0] m;
        m = (64'd1 << l) - 64'd1;
        return m[31:0];
    endfunction

    // Transmits fw[0..num] in the requested order; config is scrambled except on fsx edges
    task automatic send_frame(input logic [5:0] len_cfg, input logic [3:0] num, input bit msb,
                              input bit fsx_first, input bit fsx_last);
        int l;
        bit f;
        l = eff_len(len_cfg);
        for (int c = 0; c <= int'(num); c++) begin
            for (int i = 0; i < l; i++) begin
                f = (fsx_first && c == 0 && i == 0) || (fsx_last && c == int'(num) && i == l - 1);
                if (f) begin
                    reg_length = len_cfg;
                    reg_number = num;
                    msb_first  = msb;
                end else begin
                    reg_length = 6'($urandom);
                    reg_number = 4'($urandom);
                    msb_first  = 1'($urandom);
                end
                drive_bit(f, msb ? fw[c][l-1-i] : fw[c][i]);
            end
            exp_q.push_back({4'(c), fw[c] & word_mask(l)});
        end
        fsx  = 1'b0;
        mosi = 1'b0;
    endtask

    task automatic clear_scoreboard();
        got_q.delete();
        exp_q.delete();
        fe_cnt  = 0;
        ovf_cnt = 0;
    endtask

    task automatic test_reset();
        rst  = 1'b1;
        fsx  = 1'b0;
        mosi = 1'b1;
        tick();
        tick();
        checks++;
        if (debug !== 64'h2) begin
            errors++;
            $display("FAIL reset_debug_mosi: got %h expected %h", debug, 64'h2);
        end
        checks++;
        if ({valid, data, chan, frame_err, ovf_err, level} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: valid=%b data=%h chan=%h fe=%b ovf=%b lvl=%0d, all must be 0",
                     valid, data, chan, frame_err, ovf_err, level);
        end
        fsx = 1'b1;
        tick();
        checks++;
        if (debug !== 64'h3 || valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_fsx_ignored: debug=%h valid=%b expected debug=3 valid=0", debug, valid);
        end
        rst  = 1'b0;
        fsx  = 1'b0;
        mosi = 1'b0;
        tick();
        checks++;
        if (debug !== 64'h0) begin
            errors++;
            $display("FAIL post_reset_idle: debug=%h expected 0", debug);
        end
    endtask

    task automatic test_single();
        logic [31:0] w;
        w = 32'hA5C3_0F81;
        clear_scoreboard();
        ready      = 1'b0;
        reg_length = 6'd32;
        reg_number = 4'd0;
        msb_first  = 1'b1;
        for (int i = 0; i < 32; i++) begin
            drive_bit(i == 0, w[31-i]);
            if (i == 30) begin
                checks++;
                if (valid !== 1'b0) begin
                    errors++;
                    $display("FAIL single_early_valid: valid=%b before last bit, expected 0", valid);
                end
            end
        end
        fsx = 1'b0;
        checks++;
        if (valid !== 1'b1 || data !== w || chan !== 4'd0 || level !== 3'd1) begin
            errors++;
            $display("FAIL single_word: valid=%b data=%h chan=%0d lvl=%0d expected 1 %h 0 1",
                     valid, data, chan, level, w);
        end
        checks++;
        if (frame_err !== 1'b0 || ovf_err !== 1'b0) begin
            errors++;
            $display("FAIL single_errs: fe=%b ovf=%b expected 0 0", frame_err, ovf_err);
        end
        ready = 1'b1;
        tick();
        checks++;
        if (valid !== 1'b0 || level !== 3'd0) begin
            errors++;
            $display("FAIL single_pop: valid=%b lvl=%0d expected 0 0", valid, level);
        end
    endtask

    task automatic test_tdm();
        clear_scoreboard();
        ready = 1'b1;
        fw[0] = 32'h1234;
        fw[1] = 32'hABCD;
        fw[2] = 32'h0001;
        fw[3] = 32'hFFFF;
        send_frame(6'd16, 4'd3, 1'b1, 1'b1, 1'b0);
        repeat (3) tick();
        checks++;
        if (got_q.size() != exp_q.size() || fe_cnt != 0) begin
            errors++;
            $display("FAIL tdm_count: got %0d words fe=%0d, expected %0d words fe=0",
                     got_q.size(), fe_cnt, exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL tdm_word%0d: got %h expected %h", i, got_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_order();
        for (int o = 0; o < 2; o++) begin
            clear_scoreboard();
            ready      = 1'b1;
            reg_length = 6'd8;
            reg_number = 4'd0;
            msb_first  = (o == 1);
            for (int i = 0; i < 8; i++) drive_bit(i == 0, i == 0);
            fsx = 1'b0;
            tick();
            tick();
            checks++;
            if (got_q.size() != 1 || got_q[0] !== {4'd0, (o == 1) ? 32'h80 : 32'h01}) begin
                errors++;
                $display("FAIL order_msb%0d: got %0d words first=%h expected %h", o, got_q.size(),
                         (got_q.size() > 0) ? got_q[0] : 36'h0, (o == 1) ? 32'h80 : 32'h01);
            end
        end
        clear_scoreboard();
        fw[0] = $urandom;
        send_frame(6'd0, 4'd0, 1'($urandom), 1'b1, 1'b0);
        repeat (2) tick();
        checks++;
        if (got_q.size() != 1 || got_q[0] !== exp_q[0]) begin
            errors++;
            $display("FAIL len0_as_32: got %0d words first=%h expected %h", got_q.size(),
                     (got_q.size() > 0) ? got_q[0] : 36'h0, exp_q[0]);
        end
    endtask

    task automatic test_frame_err();
        logic [31:0] w2;
        clear_scoreboard();
        ready      = 1'b1;
        w2         = $urandom;
        reg_length = 6'd32;
        reg_number = 4'd0;
        msb_first  = 1'b1;
        for (int i = 0; i < 10; i++) drive_bit(i == 0, 1'($urandom));
        drive_bit(1'b1, w2[31]);
        checks++;
        if (frame_err !== 1'b1) begin
            errors++;
            $display("FAIL frame_err_pulse: fe=%b expected 1", frame_err);
        end
        drive_bit(1'b0, w2[30]);
        checks++;
        if (frame_err !== 1'b0) begin
            errors++;
            $display("FAIL frame_err_width: fe=%b expected 0", frame_err);
        end
        for (int i = 2; i < 32; i++) drive_bit(1'b0, w2[31-i]);
        repeat (3) tick();
        checks++;
        if (fe_cnt != 1 || got_q.size() != 1) begin
            errors++;
            $display("FAIL frame_err_count: pulses=%0d words=%0d expected 1 1", fe_cnt, got_q.size());
        end
        checks++;
        if (got_q.size() < 1 || got_q[0] !== {4'd0, w2}) begin
            errors++;
            $display("FAIL frame_err_restart: got %h expected %h",
                     (got_q.size() > 0) ? got_q[0] : 36'h0, {4'd0, w2});
        end
    endtask

    task automatic test_back_to_back();
        clear_scoreboard();
        ready = 1'b1;
        fw[0] = $urandom;
        send_frame(6'd8, 4'd0, 1'b1, 1'b1, 1'b1);
        fw[0] = $urandom;
        send_frame(6'd8, 4'd0, 1'b1, 1'b0, 1'b0);
        repeat (3) tick();
        checks++;
        if (fe_cnt != 0 || got_q.size() != 2) begin
            errors++;
            $display("FAIL b2b_count: pulses=%0d words=%0d expected 0 2", fe_cnt, got_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL b2b_word%0d: got %h expected %h", i, got_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_overflow();
        clear_scoreboard();
        ready = 1'b0;
        for (int i = 0; i < 5; i++) fw[i] = $urandom;
        send_frame(6'd8, 4'd4, 1'b1, 1'b1, 1'b0);
        checks++;
        if (ovf_err !== 1'b1 || level !== 3'd4) begin
            errors++;
            $display("FAIL ovf_pulse: ovf=%b lvl=%0d expected 1 4", ovf_err, level);
        end
        tick();
        checks++;
        if (ovf_err !== 1'b0 || ovf_cnt != 1) begin
            errors++;
            $display("FAIL ovf_width: ovf=%b pulses=%0d expected 0 1", ovf_err, ovf_cnt);
        end
        void'(exp_q.pop_back());
        ready = 1'b1;
        repeat (6) tick();
        checks++;
        if (got_q.size() != 4 || level !== 3'd0) begin
            errors++;
            $display("FAIL ovf_drain: words=%0d lvl=%0d expected 4 0", got_q.size(), level);
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL ovf_word%0d: got %h expected %h", i, got_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_full_push_pop();
        logic [31:0] w;
        clear_scoreboard();
        ready = 1'b0;
        for (int i = 0; i < 4; i++) fw[i] = $urandom;
        send_frame(6'd4, 4'd3, 1'b0, 1'b1, 1'b0);
        checks++;
        if (level !== 3'd4) begin
            errors++;
            $display("FAIL full_fill: lvl=%0d expected 4", level);
        end
        w          = $urandom;
        reg_length = 6'd4;
        reg_number = 4'd0;
        msb_first  = 1'b0;
        drive_bit(1'b1, w[0]);
        drive_bit(1'b0, w[1]);
        drive_bit(1'b0, w[2]);
        ready = 1'b1;
        drive_bit(1'b0, w[3]);
        ready = 1'b0;
        checks++;
        if (level !== 3'd4 || ovf_err !== 1'b0) begin
            errors++;
            $display("FAIL full_push_pop: lvl=%0d ovf=%b expected 4 0", level, ovf_err);
        end
        exp_q.push_back({4'd0, w & 32'hF});
        ready = 1'b1;
        repeat (7) tick();
        checks++;
        if (got_q.size() != 5 || ovf_cnt != 0) begin
            errors++;
            $display("FAIL full_drain: words=%0d ovf pulses=%0d expected 5 0", got_q.size(), ovf_cnt);
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL full_word%0d: got %h expected %h", i, got_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        clear_scoreboard();
        ready = 1'b0;
        fw[0] = $urandom;
        fw[1] = $urandom;
        send_frame(6'd8, 4'd1, 1'b1, 1'b1, 1'b0);
        checks++;
        if (level !== 3'd2) begin
            errors++;
            $display("FAIL rstmid_queued: lvl=%0d expected 2", level);
        end
        reg_length = 6'd32;
        reg_number = 4'd0;
        msb_first  = 1'b1;
        for (int i = 0; i < 7; i++) drive_bit(i == 0, 1'($urandom));
        rst = 1'b1;
        drive_bit(1'b0, 1'b1);
        checks++;
        if ({valid, data, chan, frame_err, ovf_err, level} !== '0 || debug !== 64'h2) begin
            errors++;
            $display("FAIL rstmid_outputs: valid=%b data=%h chan=%h fe=%b ovf=%b lvl=%0d debug=%h expected zeros, debug=2",
                     valid, data, chan, frame_err, ovf_err, level, debug);
        end
        rst = 1'b0;
        tick();
        clear_scoreboard();
        ready = 1'b1;
        fw[0] = $urandom;
        send_frame(6'd32, 4'd0, 1'b1, 1'b1, 1'b0);
        repeat (3) tick();
        checks++;
        if (got_q.size() != 1 || got_q[0] !== exp_q[0] || fe_cnt != 0) begin
            errors++;
            $display("FAIL rstmid_clean_frame: words=%0d first=%h fe=%0d expected 1 %h 0",
                     got_q.size(), (got_q.size() > 0) ? got_q[0] : 36'h0, fe_cnt, exp_q[0]);
        end
    endtask

    task automatic test_random();
        logic [5:0] len_cfg;
        logic [3:0] num;
        bit         msb, b2b, pending;
        clear_scoreboard();
        ready   = 1'b1;
        pending = 1'b0;
        len_cfg = 6'd8;
        num     = 4'd0;
        msb     = 1'b1;
        for (int n = 0; n < 20; n++) begin
            if (!pending) begin
                len_cfg = 6'($urandom);
                num     = 4'($urandom_range(0, 3));
                msb     = 1'($urandom);
            end
            for (int c = 0; c < 16; c++) fw[c] = $urandom;
            b2b = ($urandom_range(0, 3) == 0) && (n < 19) &&
                  !(!pending && eff_len(len_cfg) == 1 && num == 4'd0);
            send_frame(len_cfg, num, msb, !pending, b2b);
            pending = b2b;
            if (!b2b) begin
                for (int g = 0; g < int'($urandom_range(0, 2)); g++) drive_bit(1'b0, 1'($urandom));
            end
        end
        repeat (4) tick();
        checks++;
        if (got_q.size() != exp_q.size() || fe_cnt != 0 || ovf_cnt != 0) begin
            errors++;
            $display("FAIL random_count: words=%0d fe=%0d ovf=%0d expected %0d 0 0",
                     got_q.size(), fe_cnt, ovf_cnt, exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL random_word%0d: got %h expected %h", i, got_q[i], exp_q[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_tdm();
        test_order();
        test_frame_err();
        test_back_to_back();
        test_overflow();
        test_full_push_pop();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
